// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    localparam int RF_DEFAULT_W = 16;
    localparam int RF_DEFAULT_N = 8;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bulk-clear sequencer: walks a counter over every register address,
// presenting one zero-write per cycle while busy.
module rf_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int N = RF_DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    output logic                 busy,
    output logic                 clr_we,
    output logic [$clog2(N)-1:0] clr_addr
);

    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    rf_state_t     state;
    rf_state_t     state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nx;

    // State and address counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; clear is only honoured from IDLE, so a pulse while
    // busy cannot restart the walk.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            RF_IDLE: begin
                if (clear) begin
                    state_nx = RF_CLEAR;
                    cnt_nx   = '0;
                end
            end
            RF_CLEAR: begin
                if (cnt == LAST) begin
                    state_nx = RF_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + AW'(1);
                end
            end
            default: begin
                state_nx = RF_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Flop-based register file with one write port, two registered
// write-first read ports and a sequenced bulk clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W = RF_DEFAULT_W,
    parameter int N = RF_DEFAULT_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         data_in,
    input  logic [$clog2(N)-1:0] writenum,
    input  logic                 write,
    input  logic [$clog2(N)-1:0] readnum_a,
    input  logic [$clog2(N)-1:0] readnum_b,
    input  logic                 clear,
    output logic                 busy,
    output logic [W-1:0]         data_out_a,
    output logic [W-1:0]         data_out_b
);

    localparam int AW = $clog2(N);

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          ext_we;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [W-1:0]  regs [N];

    rf_clear_ctrl #(
        .N (N)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Merge the external and clear write sources; clear wins both while
    // busy and in the cycle the clear pulse is taken.
    always_comb begin
        ext_we = write & ~busy & ~clear;
        we     = clr_we | ext_we;
        waddr  = clr_we ? clr_addr : writenum;
        wdata  = clr_we ? '0 : data_in;
    end

    // Register storage, asynchronously zeroed so contents reset with the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Port A registered read with write-first bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_a <= '0;
        end else if (we && (waddr == readnum_a)) begin
            data_out_a <= wdata;
        end else begin
            data_out_a <= regs[readnum_a];
        end
    end

    // Port B registered read with write-first bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_b <= '0;
        end else if (we && (waddr == readnum_b)) begin
            data_out_b <= wdata;
        end else begin
            data_out_b <= regs[readnum_b];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 16x8 instance plus a 32x32 instance.
module tb_regfile_mp;

    logic clk;
    logic rst_n;

    // Default-parameter instance signals.
    logic        w1;
    logic [2:0]  wn1;
    logic [15:0] d1;
    logic [2:0]  ra1;
    logic [2:0]  rb1;
    logic        clr1;
    logic        busy1;
    logic [15:0] qa1;
    logic [15:0] qb1;

    // Wide instance signals.
    logic        w2;
    logic [4:0]  wn2;
    logic [31:0] d2;
    logic [4:0]  ra2;
    logic [4:0]  rb2;
    logic        clr2;
    logic        busy2;
    logic [31:0] qa2;
    logic [31:0] qb2;

    int n_tests = 0;
    int n_fail  = 0;
    int next_id = 0;

    typedef struct {
        bit          dut;
        int          id;
        bit          ca;
        logic [31:0] ea;
        bit          cb;
        logic [31:0] eb;
        bit          cbz;
        bit          ebz;
    } exp_t;

    exp_t exp_q[$];

    regfile_mp dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (d1),
        .writenum   (wn1),
        .write      (w1),
        .readnum_a  (ra1),
        .readnum_b  (rb1),
        .clear      (clr1),
        .busy       (busy1),
        .data_out_a (qa1),
        .data_out_b (qb1)
    );

    regfile_mp #(
        .W (32),
        .N (32)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (d2),
        .writenum   (wn2),
        .write      (w2),
        .readnum_a  (ra2),
        .readnum_b  (rb2),
        .clear      (clr2),
        .busy       (busy2),
        .data_out_a (qa2),
        .data_out_b (qb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL #%0d %s: got %h expected %h", id, name, act, exp);
        end
    endtask

    // Drive one cycle on the 16x8 instance and queue what must appear after the edge.
    task automatic step1(input logic w, input logic [2:0] wn, input logic [15:0] d, input logic clr,
                         input logic [2:0] ra, input bit ca, input logic [15:0] ea,
                         input logic [2:0] rb, input bit cb, input logic [15:0] eb,
                         input bit cbz, input bit ebz);
        exp_t e;
        w1 = w; wn1 = wn; d1 = d; clr1 = clr; ra1 = ra; rb1 = rb;
        e.dut = 1'b0; e.id = next_id++;
        e.ca = ca; e.ea = {16'h0, ea};
        e.cb = cb; e.eb = {16'h0, eb};
        e.cbz = cbz; e.ebz = ebz;
        exp_q.push_back(e);
        @(negedge clk);
        w1 = 1'b0; clr1 = 1'b0;
    endtask

    // Drive one cycle on the 32x32 instance; port B stays on r0, which is never written.
    task automatic step2(input logic w, input logic [4:0] wn, input logic [31:0] d, input logic clr,
                         input logic [4:0] ra, input bit ca, input logic [31:0] ea,
                         input bit cbz, input bit ebz);
        exp_t e;
        w2 = w; wn2 = wn; d2 = d; clr2 = clr; ra2 = ra;
        e.dut = 1'b1; e.id = next_id++;
        e.ca = ca; e.ea = ea;
        e.cb = ca; e.eb = 32'h0;
        e.cbz = cbz; e.ebz = ebz;
        exp_q.push_back(e);
        @(negedge clk);
        w2 = 1'b0; clr2 = 1'b0;
    endtask

    // Monitor: each edge that has a queued expectation is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #1;
                if (e.dut == 1'b0) begin
                    if (e.ca)  chk(e.id, "dut1 data_out_a", {16'h0, qa1}, e.ea);
                    if (e.cb)  chk(e.id, "dut1 data_out_b", {16'h0, qb1}, e.eb);
                    if (e.cbz) chk(e.id, "dut1 busy", {31'h0, busy1}, {31'h0, e.ebz});
                end else begin
                    if (e.ca)  chk(e.id, "dut2 data_out_a", qa2, e.ea);
                    if (e.cb)  chk(e.id, "dut2 data_out_b", qb2, e.eb);
                    if (e.cbz) chk(e.id, "dut2 busy", {31'h0, busy2}, {31'h0, e.ebz});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d tests expected completion", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        w1 = 1'b0; wn1 = '0; d1 = '0; ra1 = '0; rb1 = '0; clr1 = 1'b0;
        w2 = 1'b0; wn2 = '0; d2 = '0; ra2 = '0; rb2 = '0; clr2 = 1'b0;

        // Asynchronous reset takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk(-1, "reset data_out_a", {16'h0, qa1}, 32'h0);
        chk(-1, "reset data_out_b", {16'h0, qb1}, 32'h0);
        chk(-1, "reset busy", {31'h0, busy1}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All registers read zero after reset.
        for (int i = 0; i < 8; i++)
            step1(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 1'b1, 16'h0, 3'(7 - i), 1'b1, 16'h0, 1'b1, 1'b0);

        // Write then read one cycle later.
        step1(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        step1(1'b0, 3'd0, 16'h0,    1'b0, 3'd3, 1'b1, 16'hBEEF, 3'd5, 1'b1, 16'h0, 1'b0, 1'b0);

        // Write-first bypass on both ports.
        step1(1'b1, 3'd6, 16'h1234, 1'b0, 3'd6, 1'b1, 16'h1234, 3'd6, 1'b1, 16'h1234, 1'b0, 1'b0);
        step1(1'b0, 3'd0, 16'h0,    1'b0, 3'd6, 1'b1, 16'h1234, 3'd3, 1'b1, 16'hBEEF, 1'b0, 1'b0);

        // Fill all registers with ones.
        for (int i = 0; i < 8; i++)
            step1(1'b1, 3'(i), 16'hFFFF, 1'b0, 3'(i), 1'b1, 16'hFFFF, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Clear taken together with a write to r2: the write is dropped.
        step1(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 1'b1, 16'hFFFF, 3'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        // Eight clear cycles; writes to r0 and a re-pulse of clear are ignored.
        for (int k = 1; k <= 8; k++)
            step1(1'b1, 3'd0, 16'hAAAA, (k == 3), 3'(k - 1), 1'b1, 16'h0,
                  3'd7, 1'b1, (k == 8) ? 16'h0 : 16'hFFFF, 1'b1, (k != 8));
        for (int i = 0; i < 8; i++)
            step1(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 1'b1, 16'h0, 3'(7 - i), 1'b1, 16'h0, 1'b1, 1'b0);

        // Writes resume once idle.
        step1(1'b1, 3'd2, 16'h0F0F, 1'b0, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        step1(1'b0, 3'd0, 16'h0,    1'b0, 3'd2, 1'b1, 16'h0F0F, 3'd1, 1'b1, 16'h0, 1'b0, 1'b0);

        // Reset in the middle of a clear sequence.
        step1(1'b1, 3'd1, 16'h5555, 1'b0, 3'd0, 1'b0, 16'h0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        step1(1'b0, 3'd0, 16'h0,    1'b1, 3'd1, 1'b1, 16'h5555, 3'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++)
            step1(1'b0, 3'd0, 16'h0, 1'b0, 3'd2, 1'b1, (k < 3) ? 16'h0F0F : 16'h0, 3'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk(-2, "midclear reset busy", {31'h0, busy1}, 32'h0);
        chk(-2, "midclear reset data_out_a", {16'h0, qa1}, 32'h0);
        chk(-2, "midclear reset data_out_b", {16'h0, qb1}, 32'h0);
        #1 rst_n = 1'b1;
        step1(1'b1, 3'd4, 16'h7777, 1'b0, 3'd1, 1'b1, 16'h0, 3'd3, 1'b1, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            step1(1'b0, 3'd0, 16'h0, 1'b0, 3'(i), 1'b1, (i == 4) ? 16'h7777 : 16'h0,
                  3'(7 - i), 1'b1, (i == 3) ? 16'h7777 : 16'h0, 1'b1, 1'b0);

        // Wide instance: 32 clear cycles wipe r31.
        step2(1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        step2(1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        step2(1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        for (int k = 1; k <= 32; k++)
            step2(1'b1, 5'd31, 32'h12345678, 1'b0, 5'd31, 1'b1,
                  (k == 32) ? 32'h0 : 32'hDEADBEEF, 1'b1, (k != 32));
        step2(1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 1'b1, 32'h0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning data width in bits.
REQ-002 The block SHALL have parameter N, default 8, meaning register count; legal values are powers of two from 2 to 64.
REQ-003 The block SHALL derive localparam AW = $clog2(N) as the address width; AW is not user-settable.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port data_in, input, width W: write data.
REQ-007 The block SHALL have port writenum, input, width AW: write address.
REQ-008 The block SHALL have port write, input, width 1: write enable.
REQ-009 The block SHALL have port readnum_a, input, width AW: read port A address.
REQ-010 The block SHALL have port readnum_b, input, width AW: read port B address.
REQ-011 The block SHALL have port clear, input, width 1: a one-cycle pulse that starts the bulk-clear sequence.
REQ-012 The block SHALL have port busy, output, width 1: high while the bulk-clear sequence is in progress.
REQ-013 The block SHALL have port data_out_a, output, width W: registered read data for port A.
REQ-014 The block SHALL have port data_out_b, output, width W: registered read data for port B.

Function
REQ-015 The block SHALL hold N registers of W bits each.
REQ-016 The block SHALL write data_in into register[writenum] on a rising clk edge when write=1 and the state is IDLE.
REQ-017 Each read port SHALL present its data registered, one cycle after its address: data_out_x(t+1) = register[readnum_x(t)].
REQ-018 Each read port SHALL bypass write-first: when an internal write hits readnum_x in cycle t, data_out_x(t+1) SHALL equal the write data, not the old contents.
REQ-019 The block SHALL treat ports A and B as fully independent; both may read the same address.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR.
REQ-021 In IDLE, clear=1 SHALL cause a transition to CLEAR and load the counter with 0.
REQ-022 In CLEAR, the block SHALL write 0 into register[counter] each cycle and increment the counter.
REQ-023 When counter = N-1 is written, the FSM SHALL return to IDLE, so CLEAR lasts exactly N cycles.
REQ-024 busy SHALL equal 1 exactly when the state is CLEAR.
REQ-025 In the IDLE cycle where clear=1 is sampled, any simultaneous write SHALL be dropped (clear has priority).
REQ-026 While busy=1, external write SHALL be ignored.
REQ-027 While busy=1, clear SHALL be ignored; the sequence does not restart.
REQ-028 Reads SHALL continue during CLEAR.
REQ-029 During CLEAR, the REQ-018 bypass SHALL apply to the clear write, so a read of the address being cleared in that cycle returns 0.
REQ-030 The counter SHALL be AW bits wide and SHALL wrap only via the exit to IDLE; it is never observable externally.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately and asynchronously set all N registers to 0.
REQ-032 Asserting rst_n=0 SHALL immediately and asynchronously set data_out_a and data_out_b to 0.
REQ-033 Asserting rst_n=0 SHALL immediately and asynchronously set the state to IDLE, busy to 0 and the counter to 0.
REQ-034 Reset asserted mid-CLEAR SHALL abort the sequence; after release the block is in IDLE with all registers 0.
REQ-035 The first rising edge after rst_n deasserts SHALL be usable for a write.

Structure
REQ-036 Package regfile_pkg SHALL define enum rf_state_t {RF_IDLE, RF_CLEAR} and the constants RF_DEFAULT_W=16 and RF_DEFAULT_N=8.
REQ-037 The FSM and counter SHALL live in one sub-module, rf_clear_ctrl.
REQ-038 rf_clear_ctrl SHALL output busy, the clear-write enable and the clear address to the storage/read logic in regfile_mp.
REQ-039 Storage SHALL be a flop array (no inferred RAM macro), so that async reset of contents is possible.

Verification
REQ-040 Reset then read: pulse rst_n low, read addr 0..7 on A and B -> all data_out = 16'h0000.
REQ-041 Write then read: write 16'hBEEF to r3, then read r3 on A and r5 on B next cycle -> A=16'hBEEF, B=16'h0000, each one cycle after address.
REQ-042 Bypass: in the same cycle, write 16'h1234 to r6 and readnum_a=6 -> data_out_a=16'h1234 on the next cycle.
REQ-043 Clear with contention: fill r0..r7 with 16'hFFFF, then pulse clear together with a write of 16'hAAAA to r2 -> busy high for exactly 8 cycles, the write is dropped, writes during busy are ignored, and afterwards all registers read 0.
REQ-044 Mid-clear reset: start clear, assert rst_n at CLEAR cycle 3 -> busy=0 immediately, all registers 0, and a write is accepted on the first edge after release.
REQ-045 Parameter sweep: with W=32, N=32, write 32'hDEADBEEF to r31 and clear -> busy lasts 32 cycles and r31 reads 0.
